// File: rtl/icache_fetch_responder.sv
// Direct-mapped, read-only instruction cache between the CPU fetch port and a
// slow block-transfer instruction memory. Hits return combinationally; misses stall via BUSYWAIT.
module icache_fetch_responder #(
    parameter int NUM_BLOCKS      = 8,
    parameter int WORDS_PER_BLOCK = 4,
    parameter int MEM_ADDR_BITS   = 10,
    localparam int IDX_W   = $clog2(NUM_BLOCKS),
    localparam int OFF_W   = $clog2(WORDS_PER_BLOCK),
    localparam int BLK_LSB = OFF_W + 2,
    localparam int BLK_W   = MEM_ADDR_BITS - BLK_LSB,
    localparam int TAG_W   = BLK_W - IDX_W,
    localparam int LINE_W  = 32 * WORDS_PER_BLOCK
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [31:0]       ADDRESS,
    output logic [31:0]       INSTRUCTION,
    output logic              BUSYWAIT,
    output logic              MEM_READ,
    output logic [BLK_W-1:0]  MEM_ADDRESS,
    input  logic [LINE_W-1:0] MEM_READDATA,
    input  logic              MEM_BUSYWAIT
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] FILL  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [BLK_W-1:0]  miss_q, miss_d;
    logic [NUM_BLOCKS-1:0] valid_q;
    logic [TAG_W-1:0]  tag_q  [NUM_BLOCKS];
    logic [LINE_W-1:0] data_q [NUM_BLOCKS];
    logic [LINE_W-1:0] line_q;

    logic [OFF_W-1:0]  off;
    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    logic [IDX_W-1:0]  miss_idx;
    logic [TAG_W-1:0]  miss_tag;
    logic              hit;
    logic [LINE_W-1:0] rd_line;
    logic [31:0]       rd_words [WORDS_PER_BLOCK];

    // Upper address bits alias onto the low memory window; byte-lane bits are irrelevant.
    logic unused_addr;
    assign unused_addr = ^{ADDRESS[31:MEM_ADDR_BITS], ADDRESS[1:0]};

    assign off      = ADDRESS[BLK_LSB-1:2];
    assign idx      = ADDRESS[BLK_LSB+IDX_W-1:BLK_LSB];
    assign tag      = ADDRESS[MEM_ADDR_BITS-1:BLK_LSB+IDX_W];
    assign miss_idx = miss_q[IDX_W-1:0];
    assign miss_tag = miss_q[BLK_W-1:IDX_W];

    assign hit     = valid_q[idx] && (tag_q[idx] == tag);
    assign rd_line = data_q[idx];

    for (genvar g = 0; g < WORDS_PER_BLOCK; g++) begin : g_word
        assign rd_words[g] = rd_line[g*32 +: 32];
    end

    always_comb begin
        state_d = state_q;
        miss_d  = miss_q;
        case (state_q)
            IDLE: begin
                if (!hit) begin
                    miss_d  = ADDRESS[MEM_ADDR_BITS-1:BLK_LSB];
                    state_d = FETCH;
                end
            end
            FETCH:   if (!MEM_BUSYWAIT) state_d = FILL;
            FILL:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are forced quiet while RESET is low, independent of the clock.
    always_comb begin
        INSTRUCTION = 32'h0;
        BUSYWAIT    = 1'b0;
        MEM_READ    = 1'b0;
        MEM_ADDRESS = '0;
        if (RESET) begin
            case (state_q)
                IDLE: begin
                    BUSYWAIT = ~hit;
                    if (hit) INSTRUCTION = rd_words[off];
                end
                FETCH: begin
                    BUSYWAIT    = 1'b1;
                    MEM_READ    = 1'b1;
                    MEM_ADDRESS = miss_q;
                end
                FILL:    BUSYWAIT = 1'b1;
                default: BUSYWAIT = 1'b0;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= IDLE;
            miss_q  <= '0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            miss_q  <= miss_d;
            if (state_q == FILL) valid_q[miss_idx] <= 1'b1;
        end
    end

    // Tag/data storage is not reset; valid bits alone qualify it.
    always_ff @(posedge CLK) begin
        if (state_q == FETCH && !MEM_BUSYWAIT) line_q <= MEM_READDATA;
        if (state_q == FILL) begin
            tag_q[miss_idx]  <= miss_tag;
            data_q[miss_idx] <= line_q;
        end
    end

endmodule

// File: doc/icache_fetch_responder.md
Name: icache_fetch_responder

Overview:
- Instruction-side responder for the 8-bit CPU's fetch interface: takes the CPU's 32-bit PC and returns the 32-bit INSTRUCTION word.
- Stalls the CPU with BUSYWAIT while it fetches.
- Direct-mapped read-only instruction cache between the CPU fetch port and a slow 1 KB instruction memory that transfers 16-byte blocks.
- The CPU holds PC and freezes its own state while BUSYWAIT=1.

Parameters:
NUM_BLOCKS, 8, cache lines (power of 2); index width = log2(NUM_BLOCKS)
WORDS_PER_BLOCK, 4, 32-bit words per line; block = 128 bits
MEM_ADDR_BITS, 10, byte-address bits used; ADDRESS[31:10] ignored (aliases)

Ports:
CLK  in  1  system clock, rising edge
RESET  in  1  asynchronous, active-low reset
ADDRESS  in  32  CPU PC (byte address, word aligned; bits[1:0] ignored)
INSTRUCTION  out  32  fetched instruction word
BUSYWAIT  out  1  1 = CPU must stall and hold ADDRESS
MEM_READ  out  1  block read request to instruction memory
MEM_ADDRESS  out  6  block address (byte address[9:4])
MEM_READDATA  in  128  block data; word0 in [31:0], word3 in [127:96]
MEM_BUSYWAIT  in  1  1 = memory read in progress; data valid in the cycle it falls to 0 while MEM_READ=1

Behaviour:
- Address split with defaults: offset = ADDRESS[3:2], index = ADDRESS[6:4], tag = ADDRESS[9:7].
- Storage per line: valid bit, 3-bit tag, 128-bit data.
- Reset: RESET=0 asynchronously clears all valid bits, state to IDLE, miss address register to 0. While RESET=0: MEM_READ=0, MEM_ADDRESS=0, BUSYWAIT=0, INSTRUCTION=0. Data and tag arrays are not cleared.
- hit = valid[index] & (tag_array[index] == tag). Evaluated combinationally from ADDRESS.
- INSTRUCTION = selected word of data[index] when (state==IDLE & hit), else 32'h0.
- State IDLE:
  - BUSYWAIT = ~hit; MEM_READ=0.
  - On miss, latch ADDRESS[9:4] into the miss register at the clock edge and go to FETCH.
  - On hit, stay in IDLE. Hit latency 0 cycles: combinational, same cycle.
- State FETCH:
  - MEM_READ=1; MEM_ADDRESS = miss register; BUSYWAIT=1.
  - Stay while MEM_BUSYWAIT=1.
  - At the edge where MEM_BUSYWAIT=0, capture MEM_READDATA into a line buffer and go to FILL.
- State FILL:
  - MEM_READ=0; BUSYWAIT=1.
  - At the edge, write the line buffer to data[miss index], set tag = miss tag and valid=1, go to IDLE.
  - The next cycle in IDLE is a hit and releases BUSYWAIT.
- Miss penalty: with memory holding MEM_BUSYWAIT high for N cycles after MEM_READ rises, BUSYWAIT is high for N+2 cycles after the miss cycle.
- A miss always replaces the indexed line. There is no dirty state and no write path: instruction memory is read-only.
- Line fills always use the latched miss address. ADDRESS changes during FETCH/FILL are protocol violations; the fill still completes to the latched line, then IDLE re-evaluates the current ADDRESS.
- MEM_BUSYWAIT is ignored when MEM_READ=0.
- Reset asserted mid-FETCH/FILL: fill aborted, no array write, all lines invalid. After release, the first fetch misses.
- Addresses above 0x3FF alias onto the low 1 KB (upper bits ignored).

Test Plan:
- Cold start: RESET low 2 cycles, release, ADDRESS=0x0; memory returns block 0 = {32'h0000_0003, 32'h0000_0002, 32'h0000_0001, 32'h0000_0000} after MEM_BUSYWAIT high 5 cycles -> MEM_READ=1 with MEM_ADDRESS=6'd0; BUSYWAIT high 7 cycles; then INSTRUCTION=32'h0000_0000, BUSYWAIT=0.
- Spatial hits: after cold start, ADDRESS=0x4, 0x8, 0xC on consecutive cycles -> INSTRUCTION=1,2,3; BUSYWAIT=0 throughout; MEM_READ never asserted.
- Conflict miss: ADDRESS=0x80 (index 0, tag 1) -> miss, MEM_ADDRESS=6'd8, line 0 replaced; then ADDRESS=0x0 -> miss again, MEM_ADDRESS=6'd0.
- Independent lines: fill 0x10 and 0x20 -> both stay resident; alternating ADDRESS 0x10/0x20 -> no MEM_READ, correct words returned.
- Reset mid-fill: RESET low during FETCH cycle 3 -> MEM_READ=0 and BUSYWAIT=0 immediately, without waiting for a clock edge; after release, ADDRESS=0x0 misses even if previously cached.
- Aliasing and zero-latency memory: ADDRESS=0x400 with MEM_BUSYWAIT always 0 -> MEM_ADDRESS=6'd0; BUSYWAIT high exactly 2 cycles; the block returned is block 0.
